// File: rtl/fu_scalar_ls_queue_if.sv
// Handshake bundle for the scalar load/store unit: dispatch requests,
// dcache transaction and writeback response.
interface fu_scalar_ls_queue_if #(
    parameter int unsigned WORD_W = 32,
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned TAG_W  = 5
);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
    localparam int unsigned BE_W  = WORD_W / 8;

    logic              req_valid;
    logic              req_ready;
    logic              req_store;
    logic [1:0]        req_size;
    logic              req_unsigned;
    logic [WORD_W-1:0] req_rs1;
    logic [WORD_W-1:0] req_imm;
    logic [WORD_W-1:0] req_rs2;
    logic [TAG_W-1:0]  req_tag;
    logic              flush;

    logic [WORD_W-1:0] dmemaddr;
    logic              dmemREN;
    logic              dmemWEN;
    logic [WORD_W-1:0] dmemstore;
    logic [BE_W-1:0]   dmem_be;
    logic [WORD_W-1:0] dmem_in;
    logic              dhit_in;

    logic              resp_valid;
    logic              resp_ready;
    logic [WORD_W-1:0] resp_data;
    logic [TAG_W-1:0]  resp_tag;
    logic              resp_wen;
    logic              resp_fault;
    logic [CNT_W-1:0]  count;

    // Environment side: dispatch, dcache and writeback
    modport master (
        output req_valid, req_store, req_size, req_unsigned, req_rs1, req_imm,
               req_rs2, req_tag, flush, dmem_in, dhit_in, resp_ready,
        input  req_ready, dmemaddr, dmemREN, dmemWEN, dmemstore, dmem_be,
               resp_valid, resp_data, resp_tag, resp_wen, resp_fault, count
    );

    // Load/store unit side
    modport slave (
        input  req_valid, req_store, req_size, req_unsigned, req_rs1, req_imm,
               req_rs2, req_tag, flush, dmem_in, dhit_in, resp_ready,
        output req_ready, dmemaddr, dmemREN, dmemWEN, dmemstore, dmem_be,
               resp_valid, resp_data, resp_tag, resp_wen, resp_fault, count
    );
endinterface

// File: rtl/fu_scalar_ls_queue.sv
// Scalar load/store unit: in-order request queue feeding a single
// outstanding dcache transaction, with tagged responses to writeback.
module fu_scalar_ls_queue #(
    parameter int unsigned WORD_W = 32,
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned TAG_W  = 5
) (
    input logic            CLK,
    input logic            rst,
    fu_scalar_ls_queue_if.slave bus
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned BE_W  = WORD_W / 8;

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;

    typedef struct packed {
        logic [WORD_W-1:0] addr;
        logic [1:0]        size;
        logic              uns;
        logic              store;
        logic [WORD_W-1:0] rs2;
        logic [TAG_W-1:0]  tag;
        logic              fault;
    } entry_t;

    entry_t            q [DEPTH];
    entry_t            head_e;
    entry_t            new_e;
    logic [PTR_W-1:0]  head, tail, head_n, tail_n;
    logic [CNT_W-1:0]  cnt, cnt_n;
    state_t            state, state_n;
    logic              drain, drain_n;
    logic              push, pop, hit;

    logic [1:0]        off;
    logic [4:0]        sh;
    logic [BE_W-1:0]   lane_be;
    logic [WORD_W-1:0] lane_sdata;
    logic [WORD_W-1:0] lane;
    logic [WORD_W-1:0] load_ext;

    logic              ren_d, wen_d, rv_d, rwen_d, rfault_d, ready_d;
    logic [WORD_W-1:0] addr_d, sdata_d, rdata_d;
    logic [BE_W-1:0]   be_d;
    logic [TAG_W-1:0]  rtag_d;

    assign head_e = q[head];
    assign push   = bus.req_valid && bus.req_ready && !bus.flush;
    assign hit    = (state == S_ACCESS) && bus.dhit_in;
    assign bus.count = cnt;

    // Effective address and misalignment check at enqueue
    always_comb begin
        new_e       = '0;
        new_e.addr  = bus.req_rs1 + bus.req_imm;
        new_e.size  = bus.req_size;
        new_e.uns   = bus.req_unsigned;
        new_e.store = bus.req_store;
        new_e.rs2   = bus.req_rs2;
        new_e.tag   = bus.req_tag;
        new_e.fault = ((bus.req_size == 2'b01) && new_e.addr[0]) ||
                      (bus.req_size[1] && (new_e.addr[1:0] != 2'b00));
    end

    // Byte-lane steering for the head entry
    always_comb begin
        off        = head_e.addr[1:0];
        sh         = {off, 3'b000};
        lane       = bus.dmem_in >> sh;
        lane_be    = '1;
        lane_sdata = head_e.rs2;
        load_ext   = lane;
        unique case (head_e.size)
            2'b00: begin
                lane_be    = BE_W'(1) << off;
                lane_sdata = WORD_W'(head_e.rs2[7:0]) << sh;
                load_ext   = head_e.uns ? WORD_W'(lane[7:0])
                                        : {{(WORD_W-8){lane[7]}}, lane[7:0]};
            end
            2'b01: begin
                lane_be    = BE_W'(3) << off;
                lane_sdata = WORD_W'(head_e.rs2[15:0]) << sh;
                load_ext   = head_e.uns ? WORD_W'(lane[15:0])
                                        : {{(WORD_W-16){lane[15]}}, lane[15:0]};
            end
            default: begin
                lane_be    = '1;
                lane_sdata = head_e.rs2;
                load_ext   = lane;
            end
        endcase
    end

    // Queue pointers; flush keeps only an in-flight head
    always_comb begin
        head_n = head;
        tail_n = tail;
        cnt_n  = cnt;
        pop    = 1'b0;
        if (bus.flush) begin
            if ((state == S_ACCESS) && !bus.dhit_in) begin
                tail_n = head + PTR_W'(1);
                cnt_n  = CNT_W'(1);
            end else begin
                tail_n = head;
                cnt_n  = '0;
            end
        end else begin
            pop = ((state == S_RESP) && bus.resp_ready) || (hit && drain);
            if (push) tail_n = tail + PTR_W'(1);
            if (pop)  head_n = head + PTR_W'(1);
            cnt_n = cnt + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // FSM next state
    always_comb begin
        state_n = state;
        drain_n = drain;
        unique case (state)
            S_IDLE: begin
                if (!bus.flush && (cnt != '0))
                    state_n = head_e.fault ? S_RESP : S_ACCESS;
            end
            S_ACCESS: begin
                if (bus.flush) drain_n = 1'b1;
                if (bus.dhit_in) begin
                    state_n = (drain || bus.flush) ? S_IDLE : S_RESP;
                    drain_n = 1'b0;
                end
            end
            S_RESP: begin
                if (bus.flush || bus.resp_ready) state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    // FSM outputs, computed for the next cycle and registered
    always_comb begin
        ren_d    = 1'b0;
        wen_d    = 1'b0;
        addr_d   = '0;
        sdata_d  = '0;
        be_d     = '0;
        rv_d     = 1'b0;
        rdata_d  = '0;
        rtag_d   = '0;
        rwen_d   = 1'b0;
        rfault_d = 1'b0;
        ready_d  = (cnt_n != CNT_W'(DEPTH));
        if (state_n == S_ACCESS) begin
            ren_d   = !head_e.store;
            wen_d   = head_e.store;
            addr_d  = {head_e.addr[WORD_W-1:2], 2'b00};
            sdata_d = lane_sdata;
            be_d    = lane_be;
        end
        if (state_n == S_RESP) begin
            rv_d = 1'b1;
            if (state == S_RESP) begin
                rdata_d  = bus.resp_data;
                rtag_d   = bus.resp_tag;
                rwen_d   = bus.resp_wen;
                rfault_d = bus.resp_fault;
            end else begin
                rtag_d   = head_e.tag;
                rfault_d = head_e.fault;
                rwen_d   = !head_e.store && !head_e.fault;
                rdata_d  = (!head_e.store && !head_e.fault) ? load_ext : '0;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (rst) begin
            state          <= S_IDLE;
            drain          <= 1'b0;
            head           <= '0;
            tail           <= '0;
            cnt            <= '0;
            bus.req_ready  <= 1'b1;
            bus.dmemREN    <= 1'b0;
            bus.dmemWEN    <= 1'b0;
            bus.dmemaddr   <= '0;
            bus.dmemstore  <= '0;
            bus.dmem_be    <= '0;
            bus.resp_valid <= 1'b0;
            bus.resp_data  <= '0;
            bus.resp_tag   <= '0;
            bus.resp_wen   <= 1'b0;
            bus.resp_fault <= 1'b0;
        end else begin
            state          <= state_n;
            drain          <= drain_n;
            head           <= head_n;
            tail           <= tail_n;
            cnt            <= cnt_n;
            bus.req_ready  <= ready_d;
            bus.dmemREN    <= ren_d;
            bus.dmemWEN    <= wen_d;
            bus.dmemaddr   <= addr_d;
            bus.dmemstore  <= sdata_d;
            bus.dmem_be    <= be_d;
            bus.resp_valid <= rv_d;
            bus.resp_data  <= rdata_d;
            bus.resp_tag   <= rtag_d;
            bus.resp_wen   <= rwen_d;
            bus.resp_fault <= rfault_d;
        end
    end

    // Queue storage needs no reset; occupancy guards every read
    always_ff @(posedge CLK) begin
        if (!rst && push) q[tail] <= new_e;
    end
endmodule

// File: tb/tb_fu_scalar_ls_queue.sv
// Directed and randomized bench for fu_scalar_ls_queue against a
// byte-level reference model of the load/store rules.
`define CHK(tag, o, e) chk(tag, 64'(o), 64'(e))

module tb_fu_scalar_ls_queue;
    localparam int unsigned WORD_W = 32;
    localparam int unsigned DEPTH  = 4;
    localparam int unsigned TAG_W  = 5;

    typedef struct {
        bit          store;
        logic [1:0]  size;
        bit          uns;
        logic [31:0] rs1;
        logic [31:0] imm;
        logic [31:0] rs2;
        logic [4:0]  tag;
    } op_t;

    logic CLK = 1'b0;
    logic rst = 1'b1;
    int   n_assert = 0;
    int   n_fail   = 0;
    op_t  mq[$];

    fu_scalar_ls_queue_if #(.WORD_W(WORD_W), .DEPTH(DEPTH), .TAG_W(TAG_W)) bus ();

    fu_scalar_ls_queue #(.WORD_W(WORD_W), .DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .CLK (CLK),
        .rst (rst),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    // Cycle invariants on the registered outputs
    always @(negedge CLK) begin
        if (!rst) begin
            n_assert++;
            if ((bus.resp_valid && (bus.dmemREN || bus.dmemWEN)) !== 1'b0) begin
                n_fail++;
                $error("FAIL mon_resp_req resp_valid with active cache request");
            end
            n_assert++;
            if (!bus.dmemREN && !bus.dmemWEN && (bus.dmem_be !== 4'b0000)) begin
                n_fail++;
                $error("FAIL mon_be be=%0h outside access", bus.dmem_be);
            end
            n_assert++;
            if (bus.req_ready !== (bus.count != 3'(DEPTH))) begin
                n_fail++;
                $error("FAIL mon_ready ready=%0b count=%0d", bus.req_ready, bus.count);
            end
            n_assert++;
            if (bus.count > 3'(DEPTH)) begin
                n_fail++;
                $error("FAIL mon_count count=%0d", bus.count);
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int nbytes(input logic [1:0] size);
        return (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
    endfunction

    function automatic bit misaligned(input logic [31:0] a, input logic [1:0] size);
        return (int'(a % 4) % nbytes(size)) != 0;
    endfunction

    function automatic logic [3:0] be_of(input logic [31:0] a, input logic [1:0] size);
        logic [3:0] be;
        int off;
        off = int'(a % 4);
        be  = '0;
        for (int i = 0; i < 4; i++) be[i] = (i >= off) && (i < off + nbytes(size));
        return be;
    endfunction

    function automatic logic [31:0] store_of(input logic [31:0] a, input logic [1:0] size,
                                             input logic [31:0] rs2);
        logic [31:0] d;
        int off;
        off = int'(a % 4);
        d   = '0;
        for (int i = 0; i < 4; i++)
            if (i >= off && i < off + nbytes(size)) d[8*i +: 8] = rs2[8*(i-off) +: 8];
        return d;
    endfunction

    function automatic logic [31:0] load_of(input logic [31:0] a, input logic [1:0] size,
                                            input bit uns, input logic [31:0] word);
        logic [31:0] v;
        int off, n;
        off = int'(a % 4);
        n   = nbytes(size);
        v   = '0;
        for (int k = 0; k < n; k++) v[8*k +: 8] = word[8*(off+k) +: 8];
        if (!uns && n < 4 && v[8*n-1])
            for (int k = 8*n; k < 32; k++) v[k] = 1'b1;
        return v;
    endfunction

    task automatic drive(input op_t op);
        bus.req_store    = op.store;
        bus.req_size     = op.size;
        bus.req_unsigned = op.uns;
        bus.req_rs1      = op.rs1;
        bus.req_imm      = op.imm;
        bus.req_rs2      = op.rs2;
        bus.req_tag      = op.tag;
    endtask

    function automatic op_t mk(input bit st, input logic [1:0] sz, input bit u,
                               input logic [31:0] rs1, input logic [31:0] imm,
                               input logic [31:0] rs2, input logic [4:0] tag);
        op_t o;
        o.store = st; o.size = sz; o.uns = u; o.rs1 = rs1; o.imm = imm; o.rs2 = rs2; o.tag = tag;
        return o;
    endfunction

    function automatic op_t rnd_op();
        return mk(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  $urandom, 32'($urandom_range(0, 15)), $urandom, 5'($urandom_range(0, 31)));
    endfunction

    task automatic enqueue(input op_t op);
        drive(op);
        bus.req_valid = 1'b1;
        `CHK("enq_ready", bus.req_ready, 1);
        tick();
        bus.req_valid = 1'b0;
        mq.push_back(op);
        `CHK("enq_count", bus.count, mq.size());
    endtask

    task automatic check_reset();
        `CHK("rst_ready", bus.req_ready, 1);
        `CHK("rst_count", bus.count, 0);
        `CHK("rst_ren", bus.dmemREN, 0);
        `CHK("rst_wen", bus.dmemWEN, 0);
        `CHK("rst_be", bus.dmem_be, 0);
        `CHK("rst_addr", bus.dmemaddr, 0);
        `CHK("rst_store", bus.dmemstore, 0);
        `CHK("rst_rv", bus.resp_valid, 0);
        `CHK("rst_rdata", bus.resp_data, 0);
        `CHK("rst_rtag", bus.resp_tag, 0);
        `CHK("rst_rwen", bus.resp_wen, 0);
        `CHK("rst_rfault", bus.resp_fault, 0);
    endtask

    // Head of mq is in IDLE on entry; leaves the unit in IDLE after the pop
    task automatic serve(input int hit_delay, input int resp_delay, input logic [31:0] word);
        op_t op;
        logic [31:0] a, exp_data;
        bit flt, exp_wen;
        op  = mq.pop_front();
        a   = op.rs1 + op.imm;
        flt = misaligned(a, op.size);
        `CHK("idle_ren", bus.dmemREN | bus.dmemWEN, 0);
        `CHK("idle_rv", bus.resp_valid, 0);
        tick();
        if (flt) begin
            `CHK("flt_noreq", bus.dmemREN | bus.dmemWEN, 0);
            `CHK("flt_be", bus.dmem_be, 0);
            exp_data = '0;
            exp_wen  = 1'b0;
        end else begin
            for (int d = 0; d <= hit_delay; d++) begin
                `CHK("acc_ren", bus.dmemREN, !op.store);
                `CHK("acc_wen", bus.dmemWEN, op.store);
                `CHK("acc_addr", bus.dmemaddr, a & 32'hFFFF_FFFC);
                `CHK("acc_be", bus.dmem_be, be_of(a, op.size));
                if (op.store) `CHK("acc_sdata", bus.dmemstore, store_of(a, op.size, op.rs2));
                `CHK("acc_rv", bus.resp_valid, 0);
                if (d == hit_delay) begin
                    bus.dhit_in = 1'b1;
                    bus.dmem_in = word;
                end
                tick();
            end
            bus.dhit_in = 1'b0;
            bus.dmem_in = $urandom;
            exp_data = op.store ? 32'h0 : load_of(a, op.size, op.uns, word);
            exp_wen  = !op.store;
            `CHK("post_be", bus.dmem_be, 0);
        end
        for (int r = 0; r <= resp_delay; r++) begin
            `CHK("resp_valid", bus.resp_valid, 1);
            `CHK("resp_data", bus.resp_data, exp_data);
            `CHK("resp_tag", bus.resp_tag, op.tag);
            `CHK("resp_wen", bus.resp_wen, exp_wen);
            `CHK("resp_fault", bus.resp_fault, flt);
            `CHK("resp_noreq", bus.dmemREN | bus.dmemWEN, 0);
            if (r == resp_delay) bus.resp_ready = 1'b1;
            tick();
        end
        bus.resp_ready = 1'b0;
        `CHK("pop_rv", bus.resp_valid, 0);
        `CHK("pop_count", bus.count, mq.size());
    endtask

    initial begin
        op_t o;
        bus.req_valid = 0; bus.req_store = 0; bus.req_size = 0; bus.req_unsigned = 0;
        bus.req_rs1 = 0; bus.req_imm = 0; bus.req_rs2 = 0; bus.req_tag = 0;
        bus.flush = 0; bus.dmem_in = 0; bus.dhit_in = 0; bus.resp_ready = 0;

        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        check_reset();

        // Stray hit while idle is ignored
        bus.dhit_in = 1'b1;
        tick();
        bus.dhit_in = 1'b0;
        `CHK("stray_hit_rv", bus.resp_valid, 0);

        // Signed byte load from lane 3
        enqueue(mk(0, 2'b00, 0, 32'h1000, 32'h3, 32'h0, 5'd1));
        serve(0, 0, 32'h80FF_FFFF);
        // Halfword store into upper lanes
        enqueue(mk(1, 2'b01, 0, 32'h2000, 32'h2, 32'h1234_ABCD, 5'd2));
        serve(0, 0, $urandom);
        // Misaligned word load faults without a cache request
        enqueue(mk(0, 2'b10, 0, 32'h3000, 32'h1, 32'h0, 5'd3));
        serve(0, 0, $urandom);
        // Unsigned byte with writeback backpressure
        enqueue(mk(0, 2'b00, 1, 32'h4000, 32'h0, 32'h0, 5'd4));
        serve(1, 3, 32'h1234_5680);

        // Fill the queue while the head waits on a slow hit
        enqueue(mk(0, 2'b10, 0, 32'h5000, 32'h0, 32'h0, 5'd10));
        for (int i = 0; i < 5; i++) begin
            o = mk(0, 2'b10, 0, 32'h5100 + 32'(i*4), 32'h0, 32'h0, 5'(11 + i));
            drive(o);
            bus.req_valid = 1'b1;
            `CHK("full_ready", bus.req_ready, mq.size() < DEPTH);
            if (mq.size() < DEPTH) mq.push_back(o);
            tick();
            `CHK("full_count", bus.count, mq.size());
            `CHK("full_ren", bus.dmemREN, 1);
        end
        bus.req_valid = 1'b0;
        `CHK("full_ready_end", bus.req_ready, 0);
        o = mq.pop_front();
        bus.dhit_in = 1'b1;
        bus.dmem_in = 32'hCAFE_0001;
        tick();
        bus.dhit_in = 1'b0;
        `CHK("full_head_tag", bus.resp_tag, o.tag);
        `CHK("full_head_data", bus.resp_data, 32'hCAFE_0001);
        bus.resp_ready = 1'b1;
        tick();
        bus.resp_ready = 1'b0;
        `CHK("full_pop_count", bus.count, mq.size());
        while (mq.size() > 0) serve(0, 0, $urandom);

        // Flush while a store is in flight: request held, no response
        enqueue(mk(1, 2'b10, 0, 32'h6000, 32'h0, 32'hDEAD_BEEF, 5'd20));
        enqueue(mk(0, 2'b10, 0, 32'h6004, 32'h0, 32'h0, 5'd21));
        enqueue(mk(0, 2'b10, 0, 32'h6008, 32'h0, 32'h0, 5'd22));
        `CHK("fl_wen_pre", bus.dmemWEN, 1);
        drive(mk(0, 2'b10, 0, 32'h600C, 32'h0, 32'h0, 5'd23));
        bus.req_valid = 1'b1;
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        bus.req_valid = 1'b0;
        `CHK("fl_count", bus.count, 1);
        `CHK("fl_wen_hold", bus.dmemWEN, 1);
        `CHK("fl_rv", bus.resp_valid, 0);
        tick();
        `CHK("fl_wen_hold2", bus.dmemWEN, 1);
        bus.dhit_in = 1'b1;
        tick();
        bus.dhit_in = 1'b0;
        mq.delete();
        `CHK("fl_drain_rv", bus.resp_valid, 0);
        `CHK("fl_drain_count", bus.count, 0);
        `CHK("fl_drain_wen", bus.dmemWEN, 0);
        tick();
        `CHK("fl_after_rv", bus.resp_valid, 0);

        // Flush while a fault response is pending
        enqueue(mk(0, 2'b01, 0, 32'h7001, 32'h0, 32'h0, 5'd25));
        tick();
        `CHK("flr_rv", bus.resp_valid, 1);
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        mq.delete();
        `CHK("flr_rv_off", bus.resp_valid, 0);
        `CHK("flr_count", bus.count, 0);

        // Randomized ops through the full handshake
        for (int i = 0; i < 40; i++) begin
            enqueue(rnd_op());
            serve($urandom_range(0, 3), $urandom_range(0, 2), $urandom);
        end

        // Reset in the middle of a load access
        enqueue(mk(0, 2'b10, 0, 32'h8000, 32'h0, 32'h0, 5'd30));
        tick();
        `CHK("mid_ren", bus.dmemREN, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        mq.delete();
        check_reset();
        tick();
        `CHK("post_rst_rv", bus.resp_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/fu_scalar_ls_queue.md
Name: fu_scalar_ls_queue

Overview:
Parametrised next-generation scalar load/store functional unit. It accepts issued scalar memory ops into a DEPTH-entry in-order request queue and supports byte/half/word sizes with sign/zero extension, byte enables and misalignment faults. It performs one dcache transaction at a time on a REN/WEN/dhit handshake and returns tagged responses to writeback via valid/ready. It sits between the dispatch stage and the scalar dcache.

Parameters:
WORD_W, 32, data/address width (multiple of 8, ≥32)
DEPTH, 4, request queue entries (power of 2, ≥2)
TAG_W, 5, destination/scoreboard tag width

Ports:
CLK  in  1  clock
rst  in  1  synchronous active-high reset
req_valid  in  1  op offered
req_ready  out  1  queue can accept (= !full)
req_store  in  1  1 store, 0 load
req_size  in  2  00 byte, 01 half, 10 word (11 treated as word)
req_unsigned  in  1  zero-extend load
req_rs1  in  WORD_W  base
req_imm  in  WORD_W  offset
req_rs2  in  WORD_W  store data (low bits used)
req_tag  in  TAG_W  tag
flush  in  1  discard all pending ops
dmemaddr  out  WORD_W  word-aligned address
dmemREN  out  1  read request
dmemWEN  out  1  write request
dmemstore  out  WORD_W  lane-aligned store data
dmem_be  out  WORD_W/8  byte enables
dmem_in  in  WORD_W  load data, valid with dhit_in
dhit_in  in  1  transaction complete
resp_valid  out  1  response available
resp_ready  in  1  writeback accepts
resp_data  out  WORD_W  extended load data (0 for stores/faults)
resp_tag  out  TAG_W  tag of op
resp_wen  out  1  1 only for non-faulting load
resp_fault  out  1  misaligned access
count  out  $clog2(DEPTH)+1  queue occupancy

Behaviour:
- Reset (synchronous, rst high at CLK edge): queue empty, count=0, FSM IDLE; req_ready=1; dmemREN=dmemWEN=0, dmem_be=0, dmemaddr=dmemstore=0; resp_valid=resp_wen=resp_fault=0, resp_data=0, resp_tag=0. Reset mid-transaction abandons it with no response.
- Enqueue on req_valid&&req_ready: store addr=rs1+imm (mod 2^WORD_W), size, unsigned, store, rs2, tag, fault. fault=1 if half&&addr[0], or word&&addr[1:0]!=0.
- No full-bypass: when full, req_ready=0 even if a pop occurs the same cycle. Same-cycle push and pop with 0<count<DEPTH keeps count unchanged. Pointers wrap modulo DEPTH.
- FSM, head entry only, strictly in order:
  - IDLE: if count>0 and head.fault -> RESP; elif count>0 -> ACCESS.
  - ACCESS: dmemREN=!store, dmemWEN=store, dmemaddr={addr[W-1:2],2'b00}. Outputs held stable until dhit_in. On dhit_in, latch the extracted load result -> RESP.
  - RESP: resp_valid=1; fields from head/latch. On resp_ready, pop head -> IDLE.
- Byte lanes, off=addr[1:0]:
  - byte: be=1<<off, dmemstore has rs2[7:0] in lane off.
  - half: be=2'b11<<off, rs2[15:0] at off.
  - word: be all ones, rs2.
  - Load extract uses the same lanes; sign-extend unless unsigned.
  - Unused dmemstore lanes are 0. be=0 outside ACCESS.
- Latency: accept at edge T -> IDLE sees entry -> ACCESS in cycle T+1 -> dhit same cycle -> resp_valid in cycle T+2. Fault: resp_valid in cycle T+1. Back-to-back ops: 3 cycles/op minimum.
- resp_valid held with stable fields until resp_ready.
- flush (priority over same-cycle enqueue, which is dropped):
  - IDLE/RESP: queue emptied, resp_valid deasserts next cycle, -> IDLE.
  - ACCESS: non-head entries discarded immediately. Cache request stays asserted until dhit_in; the head is then popped with no response (drain flag) -> IDLE. A store still commits.
- dhit_in outside ACCESS is ignored.

Test Plan:
- Load byte, rs1=0x1000, imm=3, req_size=00, signed, dmem_in=0x80FF_FFFF -> dmemaddr=0x1000, be=4'b1000, resp_data=0xFFFF_FF80, resp_wen=1, resp_valid 2 cycles after accept.
- Store half, addr=0x2002, rs2=0x1234_ABCD -> dmemWEN=1, be=4'b1100, dmemstore=0xABCD_0000; response resp_wen=0, resp_fault=0.
- Load word at 0x3001 -> no REN/WEN ever, resp_fault=1, resp_data=0, resp_valid in cycle after accept.
- dhit_in held low 5 cycles with 4 more ops offered -> count reaches 4, req_ready=0, further req_valid not accepted; after hit plus responses, tags return in enqueue order.
- flush during ACCESS with 3 queued, dhit after 2 cycles -> no resp_valid, count=0 the cycle after dhit, REN held until dhit.
- resp_ready low 3 cycles on a load (unsigned byte 0x80) -> resp_data=0x0000_0080 stable, no new cache request until pop; rst asserted mid-ACCESS -> all outputs at reset values the next cycle.
